// File: rtl/uart_frame_tx.sv
// uart_frame_tx: byte-stream UART transmitter with a small input FIFO.
// Each byte leaves as start, 8 data bits LSB first, optional even parity, one stop.
// Optional feature: define UART_TX_PARITY_EN to add the even parity bit (8E1);
// without it the frame is 8N1 and the parity state/logic are not built.
// rst_n is an asynchronous, ACTIVE-HIGH reset despite its name.

module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              CW      = $clog2(CLKS_PER_BIT);
    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]     FULL    = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------- FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic [7:0]    head;

    assign in_ready = (fifo_count != FULL);
    assign push     = in_valid & in_ready;
    assign head     = mem[rd_ptr];

    // Storage needs no reset: contents are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- Frame FSM ----------------
    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shift, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    logic          not_empty;

    assign bit_end   = (cnt == CNT_MAX);
    assign not_empty = (fifo_count != '0);

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;

    // Parity is captured from the whole byte at load, since shift is consumed.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) par_q <= 1'b0;
        else       par_q <= par_d;
    end
`endif

    // State and datapath registers; tx is registered from the current state,
    // so the line lags the state by one cycle and can never glitch.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            shift <= shift_d;
            tx_q  <= tx_d;
        end
    end

    // Next-state, FIFO pop and line level.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shift_d = shift;
        tx_d    = 1'b1;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state)
            IDLE: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DATA: begin
                tx_d = shift[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift[7:1]};
                    idx_d   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = par_q;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next frame with no idle gap.
                    if (not_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = START;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state != IDLE) | not_empty;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: directed timing checks plus a random
// byte stream decoded by an independent line receiver and a byte scoreboard.

module tb_uart_frame_tx;

    localparam int C = 4;
    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic       mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int         starts[$];

    uart_frame_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Expected line levels of one frame, index 0 = start bit.
    function automatic logic [10:0] frame(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("send_timeout", w < 1000, 1);
        exp_q.push_back(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", w < 3000, 1);
        repeat (2*C) @(negedge clk);
    endtask

    task automatic chk_gaps(input string tag, input int n);
        chk({tag, "_n"}, starts.size(), n);
        for (int i = 1; i < starts.size(); i++)
            chk(tag, starts[i] - starts[i-1], F*C);
    endtask

    // Line receiver: samples mid-bit, knows nothing of the DUT internals.
    initial begin : mon
        logic [7:0] d, e;
        forever begin
            @(negedge clk);
            if (mon_en && tx == 1'b0) begin
                starts.push_back(cyc);
                repeat (C/2) @(negedge clk);
                chk("rx_start", tx, 0);
                d = '0;
                for (int k = 0; k < 8; k++) begin
                    repeat (C) @(negedge clk);
                    d[k] = tx;
                end
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected", 1, 0);
                    e = d;
                end else begin
                    e = exp_q.pop_front();
                end
                chk("rx_byte", d, e);
`ifdef UART_TX_PARITY_EN
                repeat (C) @(negedge clk);
                chk("rx_parity", tx, ^e);
`endif
                repeat (C) @(negedge clk);
                chk("rx_stop", tx, 1);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [10:0] fb;
        int          full_cnt [5] = '{1, 1, 2, 3, 4};

        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset values, then a long idle stretch.
        repeat (3) @(negedge clk);
        chk("rst_vals", {tx, busy, in_ready, fifo_count}, {1'b1, 1'b0, 1'b1, 3'd0});
        rst_n = 1'b0;
        repeat (50) begin
            @(negedge clk);
            chk("idle", {tx, busy, in_ready, fifo_count}, {1'b1, 1'b0, 1'b1, 3'd0});
        end

        // Single 0x55: exact latency and bit-by-bit line shape.
        mon_en = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        exp_q.push_back(8'h55);
        fb = frame(8'h55);
        @(negedge clk);                 // after accept edge N
        in_valid = 1'b0;
        chk("lat_cnt_n", fifo_count, 1);
        chk("lat_tx_n", tx, 1);
        @(negedge clk);                 // after N+1
        chk("lat_tx_n1", tx, 1);
        chk("lat_cnt_n1", fifo_count, 0);
        chk("lat_busy", busy, 1);
        for (int b = 0; b < F; b++)
            for (int c = 0; c < C; c++) begin
                @(negedge clk);
                chk("bit55", tx, fb[b]);
            end
        chk("busy_end", busy, 0);
        drain();

`ifdef UART_TX_PARITY_EN
        // Parity frames, sent back-to-back.
        starts.delete();
        send_byte(8'h07);
        send_byte(8'h03);
        drain();
        chk_gaps("par_gap", 2);
`endif

        // FIFO full: A1 pops at once, A2..A5 fill the FIFO, A6 stalls.
        starts.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA1;
        for (int k = 0; k < 6; k++) exp_q.push_back(8'(161 + k));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("full_cnt", fifo_count, full_cnt[k]);
            in_data = 8'(162 + k);
        end
        chk("full_rdy", in_ready, 0);
        repeat (36) begin
            @(negedge clk);
            chk("stall_rdy", in_ready, 0);
            chk("stall_cnt", fifo_count, 4);
        end
        @(negedge clk);                 // first frame popped the next byte
        chk("freed_cnt", fifo_count, 3);
        chk("freed_rdy", in_ready, 1);
        @(negedge clk);                 // A6 accepted
        in_valid = 1'b0;
        chk("a6_cnt", fifo_count, 4);
        drain();
        chk_gaps("full_gap", 6);

        // Push on the same edge STOP pops the head.
        starts.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back(8'(177 + k));
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hB1;
        @(negedge clk);
        in_data  = 8'hB2;
        @(negedge clk);                 // B1 popped, B2 pushed together
        in_valid = 1'b0;
        chk("pp_idle_cnt", fifo_count, 1);
        repeat (39) @(negedge clk);
        chk("pp_pre_cnt", fifo_count, 1);
        in_valid = 1'b1;
        in_data  = 8'hB3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pp_cnt", fifo_count, 1);
        drain();
        chk_gaps("pp_gap", 3);

        // Random stream with random idle gaps.
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            send_byte(8'($urandom));
        end
        drain();

        // Reset during D3 of 0xF0 with two bytes queued.
        mon_en = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hF0;
        @(negedge clk);
        in_data  = 8'hC1;
        @(negedge clk);
        in_data  = 8'hC2;
        @(negedge clk);                 // after edge that registered start
        in_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_tx", tx, 0);
        chk("pre_rst_cnt", fifo_count, 2);
        rst_n = 1'b1;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_cnt", fifo_count, 0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (60) begin
            @(negedge clk);
            chk("post_rst", {tx, busy, fifo_count}, {1'b1, 1'b0, 3'd0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
